// File: rtl/cache_repl_pkg.sv
// rtl/cache_repl_pkg.sv - shared types, constants and index helpers for cache_repl_unit
package cache_repl_pkg;

    typedef enum logic [1:0] {
        REPL_PLRU = 2'd0,
        REPL_RAND = 2'd1,
        REPL_RR   = 2'd2
    } repl_mode_e;

    // Helpers work on a fixed maximum width; callers pad or truncate with casts.
    localparam int MAX_WAYS = 64;
    localparam int IDX_W    = 6;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_WAYS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [MAX_WAYS-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return MAX_WAYS'(1) << idx;
    endfunction

    // Index of the lowest clear bit; 0 when every bit is set.
    function automatic logic [IDX_W-1:0] lowest_zero(input logic [MAX_WAYS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (!v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_repl_unit_if.sv
// rtl/cache_repl_unit_if.sv - victim request / touch bus between tag pipeline and replacer
interface cache_repl_unit_if
    import cache_repl_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 128
);
    localparam int SW = $clog2(SETS);

    logic            req_valid;
    logic [SW-1:0]   req_set;
    logic [WAYS-1:0] req_vld_way;
    logic            victim_valid;
    logic [WAYS-1:0] victim_way;
    logic            upd_valid;
    logic [SW-1:0]   upd_set;
    logic [WAYS-1:0] upd_way;
    logic            upd_fill;

    modport master (
        output req_valid, req_set, req_vld_way,
        output upd_valid, upd_set, upd_way, upd_fill,
        input  victim_valid, victim_way
    );

    modport slave (
        input  req_valid, req_set, req_vld_way,
        input  upd_valid, upd_set, upd_way, upd_fill,
        output victim_valid, victim_way
    );

endinterface

// File: rtl/cache_repl_unit_plru_tree.sv
// rtl/cache_repl_unit_plru_tree.sv - combinational tree-PLRU walk and touch for one set
module plru_tree
    import cache_repl_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         nodes,
    input  logic [$clog2(WAYS)-1:0] touch_idx,
    output logic [$clog2(WAYS)-1:0] victim_idx,
    output logic [WAYS-2:0]         nodes_next
);
    localparam int IW = $clog2(WAYS);

    // Walk from the root; each node bit picks the child (0 left, 1 right), MSB of the index first.
    always_comb begin : p_walk
        int n;
        n          = 0;
        victim_idx = '0;
        for (int l = 0; l < IW; l++) begin
            victim_idx[IW-1-l] = nodes[n];
            n = 2 * n + 1 + int'(nodes[n]);
        end
    end

    // Follow the touched way's path and flip each node on it to point away from that way.
    always_comb begin : p_touch
        int   n;
        logic dir;
        n          = 0;
        nodes_next = nodes;
        for (int l = 0; l < IW; l++) begin
            dir           = touch_idx[IW-1-l];
            nodes_next[n] = ~dir;
            n = 2 * n + 1 + int'(dir);
        end
    end

endmodule

// File: rtl/cache_repl_unit.sv
// rtl/cache_repl_unit.sv - per-set victim selection (PLRU / LFSR / round-robin), optional REPL_WAY_LOCK_EN way locking
module cache_repl_unit
    import cache_repl_pkg::*;
#(
    parameter int          WAYS      = 4,
    parameter int          SETS      = 128,
    parameter int          MODE      = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            cache_clk,
    input  logic            rst,
`ifdef REPL_WAY_LOCK_EN
    input  logic [WAYS-1:0] lock_mask,
`endif
    cache_repl_unit_if.slave bus
);
    localparam int IW = $clog2(WAYS);

    if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0 || WAYS > MAX_WAYS) begin : g_bad_ways
        $error("cache_repl_unit: WAYS must be a power of 2 between 2 and %0d", MAX_WAYS);
    end
    if (SETS < 2 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
        $error("cache_repl_unit: SETS must be a power of 2");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("cache_repl_unit: LFSR_SEED must be nonzero");
    end

    logic                upd_ok;
    logic [IW-1:0]       upd_idx;
    logic [IW-1:0]       pol_idx;
    logic [WAYS-1:0]     lock_w;
    logic [MAX_WAYS-1:0] busy_pad;
    logic [MAX_WAYS-1:0] lock_pad;
    logic [WAYS-1:0]     pick_oh;
    logic                sink_unused;

`ifdef REPL_WAY_LOCK_EN
    assign lock_w = lock_mask;
`else
    assign lock_w = '0;
`endif

    // Non-one-hot touches are dropped entirely.
    assign upd_ok      = bus.upd_valid && $onehot(bus.upd_way);
    assign upd_idx     = IW'(onehot2idx(MAX_WAYS'(bus.upd_way)));
    assign sink_unused = ^{bus.upd_fill, upd_ok, upd_idx, bus.upd_set};

    if (MODE == int'(REPL_PLRU)) begin : g_plru
        logic [WAYS-2:0] node_q [SETS];
        logic [WAYS-2:0] touch_cur;
        logic [WAYS-2:0] touch_nxt;
        logic [WAYS-2:0] walk_cur;
        logic [WAYS-2:0] walk_next_unused;
        logic [IW-1:0]   touch_victim_unused;

        assign touch_cur = node_q[bus.upd_set];
        // A same-set touch in this cycle is forwarded into the walk.
        assign walk_cur  = (upd_ok && bus.upd_set == bus.req_set) ? touch_nxt : node_q[bus.req_set];

        plru_tree #(.WAYS(WAYS)) u_touch (
            .nodes      (touch_cur),
            .touch_idx  (upd_idx),
            .victim_idx (touch_victim_unused),
            .nodes_next (touch_nxt)
        );

        plru_tree #(.WAYS(WAYS)) u_walk (
            .nodes      (walk_cur),
            .touch_idx  ('0),
            .victim_idx (pol_idx),
            .nodes_next (walk_next_unused)
        );

        // Commit the touched set's node bits.
        always_ff @(posedge cache_clk) begin
            if (rst) begin
                for (int s = 0; s < SETS; s++) node_q[s] <= '0;
            end else if (upd_ok) begin
                node_q[bus.upd_set] <= touch_nxt;
            end
        end
    end else if (MODE == int'(REPL_RAND)) begin : g_rand
        logic [15:0] lfsr_q;

        // Free-running LFSR, shared by all sets.
        always_ff @(posedge cache_clk) begin
            if (rst) lfsr_q <= LFSR_SEED;
            else     lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end

        assign pol_idx = lfsr_q[IW-1:0];
    end else if (MODE == int'(REPL_RR)) begin : g_rr
        logic [IW-1:0] ptr_q [SETS];
        logic [IW-1:0] fill_ptr;

        // Wraps naturally from WAYS-1 to 0 in IW bits.
        assign fill_ptr = upd_idx + IW'(1);
        assign pol_idx  = (upd_ok && bus.upd_fill && bus.upd_set == bus.req_set) ? fill_ptr
                                                                                 : ptr_q[bus.req_set];

        // Only fills move the pointer; hits leave it alone.
        always_ff @(posedge cache_clk) begin
            if (rst) begin
                for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
            end else if (upd_ok && bus.upd_fill) begin
                ptr_q[bus.upd_set] <= fill_ptr;
            end
        end
    end else begin : g_bad_mode
        $error("cache_repl_unit: MODE must be 0, 1 or 2");
        assign pol_idx = '0;
    end

    // Pad with ones so padding bits never look invalid or unlocked.
    always_comb begin
        busy_pad           = '1;
        busy_pad[WAYS-1:0] = bus.req_vld_way | lock_w;
        lock_pad           = '1;
        lock_pad[WAYS-1:0] = lock_w;
    end

    // Prefer an invalid unlocked way; otherwise the policy pick, moved to the lowest unlocked way if needed.
    always_comb begin
        pick_oh = '0;
        if (!(&busy_pad)) begin
            pick_oh = WAYS'(idx2onehot(lowest_zero(busy_pad)));
        end else if (!(&lock_w)) begin
            if (!(&bus.req_vld_way) || lock_w[pol_idx]) begin
                pick_oh = WAYS'(idx2onehot(lowest_zero(lock_pad)));
            end else begin
                pick_oh = WAYS'(idx2onehot(IDX_W'(pol_idx)));
            end
        end
    end

    // Register the victim one cycle after the request; reset drops any pending request.
    always_ff @(posedge cache_clk) begin
        if (rst) begin
            bus.victim_valid <= 1'b0;
            bus.victim_way   <= '0;
        end else begin
            bus.victim_valid <= bus.req_valid;
            if (bus.req_valid) bus.victim_way <= pick_oh;
        end
    end

endmodule

// File: tb/tb_cache_repl_unit.sv
// tb/tb_cache_repl_unit.sv - scoreboard bench running PLRU, LFSR and round-robin instances side by side
module tb_cache_repl_unit;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       cache_clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [6:0] req_set;
    logic [3:0] req_vld;
    logic       upd_valid;
    logic [6:0] upd_set;
    logic [3:0] upd_way;
    logic       upd_fill;
    logic [3:0] lock_m;

    logic [2:0] vv_a;
    logic [3:0] way_a [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 cache_clk = ~cache_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cache_repl_unit_if #(.WAYS(4), .SETS(128)) bus ();

        assign bus.req_valid   = req_valid;
        assign bus.req_set     = req_set;
        assign bus.req_vld_way = req_vld;
        assign bus.upd_valid   = upd_valid;
        assign bus.upd_set     = upd_set;
        assign bus.upd_way     = upd_way;
        assign bus.upd_fill    = upd_fill;
        assign vv_a[g]         = bus.victim_valid;
        assign way_a[g]        = bus.victim_way;

        cache_repl_unit #(.WAYS(4), .SETS(128), .MODE(g), .LFSR_SEED(SEED)) u_dut (
            .cache_clk (cache_clk),
            .rst       (rst),
`ifdef REPL_WAY_LOCK_EN
            .lock_mask (lock_m),
`endif
            .bus       (bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [2:0]  plru_m [128];
    logic [1:0]  rr_m   [128];
    logic [15:0] lfsr_m;
    logic [3:0]  exp_q  [3][$];

    function automatic int plru_walk(input logic [2:0] n);
        if (!n[0]) return n[1] ? 1 : 0;
        return n[2] ? 3 : 2;
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] n, input int w);
        logic [2:0] r;
        r = n;
        if (w < 2) begin
            r[0] = 1'b1;
            r[1] = (w == 0);
        end else begin
            r[0] = 1'b0;
            r[2] = (w == 2);
        end
        return r;
    endfunction

    function automatic logic [3:0] pick(input logic [3:0] vld, input logic [3:0] lk, input int pol);
        logic [3:0] inv;
        inv = ~vld;
        if (lk == 4'hF) return 4'h0;
        for (int i = 0; i < 4; i++) if (inv[i] && !lk[i]) return 4'(1 << i);
        if (inv != 4'h0 || lk[pol]) begin
            for (int i = 0; i < 4; i++) if (!lk[i]) return 4'(1 << i);
        end
        return 4'(1 << pol);
    endfunction

    // Update the model and push expectations on each rising edge.
    always @(posedge cache_clk) begin
        if (rst) begin
            for (int s = 0; s < 128; s++) begin
                plru_m[s] = 3'b000;
                rr_m[s]   = 2'b00;
            end
            lfsr_m = SEED;
            for (int i = 0; i < 3; i++) exp_q[i].delete();
        end else begin
            if (upd_valid && $onehot(upd_way)) begin
                int w;
                w = 0;
                for (int i = 0; i < 4; i++) if (upd_way[i]) w = i;
                plru_m[upd_set] = plru_touch(plru_m[upd_set], w);
                if (upd_fill) rr_m[upd_set] = 2'((w + 1) % 4);
            end
            if (req_valid) begin
                exp_q[0].push_back(pick(req_vld, lock_m, plru_walk(plru_m[req_set])));
                exp_q[1].push_back(pick(req_vld, lock_m, int'(lfsr_m[1:0])));
                exp_q[2].push_back(pick(req_vld, lock_m, int'(rr_m[req_set])));
            end
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end
    end

    // Compare DUT outputs against the scoreboard on the falling edge.
    always @(negedge cache_clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("valid_m%0d", i), 32'(vv_a[i]), 32'(exp_q[i].size() != 0));
            if (exp_q[i].size() != 0) check($sformatf("way_m%0d", i), 32'(way_a[i]), 32'(exp_q[i].pop_front()));
        end
    end

    task automatic clear_inputs();
        req_valid = 1'b0;
        req_set   = '0;
        req_vld   = 4'hF;
        upd_valid = 1'b0;
        upd_set   = '0;
        upd_way   = '0;
        upd_fill  = 1'b0;
    endtask

    task automatic do_req(input logic [6:0] s, input logic [3:0] v);
        req_valid = 1'b1;
        req_set   = s;
        req_vld   = v;
        @(negedge cache_clk);
        req_valid = 1'b0;
    endtask

    task automatic do_touch(input logic [6:0] s, input logic [3:0] w, input logic f);
        upd_valid = 1'b1;
        upd_set   = s;
        upd_way   = w;
        upd_fill  = f;
        @(negedge cache_clk);
        upd_valid = 1'b0;
    endtask

    task automatic do_both(input logic [6:0] s, input logic [3:0] w, input logic f);
        upd_valid = 1'b1;
        upd_set   = s;
        upd_way   = w;
        upd_fill  = f;
        req_valid = 1'b1;
        req_set   = s;
        req_vld   = 4'hF;
        @(negedge cache_clk);
        upd_valid = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        lock_m = 4'h0;
        clear_inputs();
        repeat (3) @(negedge cache_clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_valid_m%0d", i), 32'(vv_a[i]), 32'd0);
            check($sformatf("rst_way_m%0d", i), 32'(way_a[i]), 32'd0);
        end
        rst = 1'b0;

        do_req(7'd5, 4'b1111);
        check("t1_valid", 32'(vv_a[0]), 32'd1);
        check("t1_plru", 32'(way_a[0]), 32'b0001);
        check("t1_rr", 32'(way_a[2]), 32'b0001);

        do_req(7'd5, 4'b1011);
        for (int i = 0; i < 3; i++) check($sformatf("t2_inv_m%0d", i), 32'(way_a[i]), 32'b0100);
        do_req(7'd5, 4'b0000);
        for (int i = 0; i < 3; i++) check($sformatf("t2_allinv_m%0d", i), 32'(way_a[i]), 32'b0001);

        do_touch(7'd3, 4'b0001, 1'b0);
        do_touch(7'd3, 4'b0100, 1'b0);
        do_touch(7'd3, 4'b0010, 1'b0);
        do_req(7'd3, 4'b1111);
        check("t3_plru_a", 32'(way_a[0]), 32'b1000);
        do_touch(7'd3, 4'b1000, 1'b0);
        do_req(7'd3, 4'b1111);
        check("t3_plru_b", 32'(way_a[0]), 32'b0001);

        do_touch(7'd0, 4'b0001, 1'b1);
        do_req(7'd0, 4'b1111);
        check("t4_rr_step", 32'(way_a[2]), 32'b0010);
        do_touch(7'd0, 4'b0010, 1'b1);
        do_touch(7'd0, 4'b0100, 1'b1);
        do_touch(7'd0, 4'b1000, 1'b1);
        do_req(7'd0, 4'b1111);
        check("t4_rr_wrap", 32'(way_a[2]), 32'b0001);
        do_touch(7'd0, 4'b0100, 1'b0);
        do_req(7'd0, 4'b1111);
        check("t4_rr_hit", 32'(way_a[2]), 32'b0001);

        do_both(7'd7, 4'b0001, 1'b0);
        check("t5_plru_fwd", 32'(way_a[0]), 32'b0100);
        do_both(7'd9, 4'b0010, 1'b1);
        check("t5_rr_fwd", 32'(way_a[2]), 32'b0100);

        do_touch(7'd11, 4'b0011, 1'b1);
        do_req(7'd11, 4'b1111);
        check("bad_touch_plru", 32'(way_a[0]), 32'b0001);
        check("bad_touch_rr", 32'(way_a[2]), 32'b0001);

        req_valid = 1'b1;
        req_set   = 7'd3;
        @(negedge cache_clk);
        req_set   = 7'd0;
        @(negedge cache_clk);
        req_valid = 1'b0;
        @(negedge cache_clk);

`ifdef REPL_WAY_LOCK_EN
        lock_m = 4'b0011;
        do_req(7'd20, 4'b1111);
        check("t6_lock_plru", 32'(way_a[0]), 32'b0100);
        lock_m = 4'b1111;
        do_req(7'd20, 4'b1111);
        check("t6_all_valid", 32'(vv_a[0]), 32'd1);
        check("t6_all_way", 32'(way_a[0]), 32'b0000);
        lock_m = 4'b0000;
`endif

        req_valid = 1'b1;
        req_set   = 7'd3;
        rst       = 1'b1;
        @(negedge cache_clk);
        check("rst_mid_req", 32'(vv_a[0]), 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        do_req(7'd3, 4'b1111);
        check("post_rst_plru", 32'(way_a[0]), 32'b0001);

        for (int k = 0; k < 400; k++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_set   = 7'($urandom_range(0, 7));
            req_vld   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            upd_valid = 1'($urandom_range(0, 1));
            upd_set   = ($urandom_range(0, 1) == 0) ? req_set : 7'($urandom_range(0, 7));
            upd_way   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            upd_fill  = 1'($urandom_range(0, 1));
`ifdef REPL_WAY_LOCK_EN
            lock_m    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
`endif
            @(negedge cache_clk);
        end

        clear_inputs();
        lock_m = 4'h0;
        repeat (2) @(negedge cache_clk);
        for (int i = 0; i < 3; i++) check($sformatf("drain_m%0d", i), 32'(exp_q[i].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
